// File: rtl/pcseq_pkg.sv
// -----------------------------------------------------------------------------
// pcseq_pkg
//   Shared definitions for the program-counter sequencer slice.
//   - FSM state encodings (S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT)
//   - Opcode encodings (OP_ADV, OP_JNO, OP_JMP, OP_HALT)
//   - Instruction field-slice helpers: an instruction word is
//     {opcode[1:0], target[PC_W-1:0]}, so the opcode sits directly above
//     the jump target.
//   Build option: PCSEQ_HALT_EN (consumed by pc_sequencer / pc_next_mux)
//   enables the S_HALT state; the encodings here are the same either way.
// -----------------------------------------------------------------------------
package pcseq_pkg;

  // FSM state encoding, kept as plain constants for older tool flows.
  typedef logic [2:0] pcseq_state_t;

  localparam pcseq_state_t S_IDLE  = 3'd0;
  localparam pcseq_state_t S_FETCH = 3'd1;
  localparam pcseq_state_t S_WAIT  = 3'd2;
  localparam pcseq_state_t S_EXEC  = 3'd3;
  localparam pcseq_state_t S_HALT  = 3'd4;

  // Opcode encoding carried in the top two bits of every instruction.
  localparam logic [1:0] OP_ADV  = 2'b00;  // pc <= pc + 1
  localparam logic [1:0] OP_JNO  = 2'b01;  // jump if no overflow pending
  localparam logic [1:0] OP_JMP  = 2'b10;  // unconditional jump
  localparam logic [1:0] OP_HALT = 2'b11;  // halt (or ADV when halting is disabled)

  localparam int OPCODE_W         = 32'sd2;
  localparam int INSTR_TARGET_LSB = 32'sd0;

  // Total instruction width for a given PC width.
  function automatic int instr_width(input int pc_w);
    return pc_w + OPCODE_W;
  endfunction

  // Bit position of the opcode field's LSB for a given PC width.
  function automatic int instr_opcode_lsb(input int pc_w);
    return pc_w;
  endfunction

endpackage : pcseq_pkg

// File: rtl/pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
//   Combinational selection of the PC and overflow flag that the sequencer
//   commits in S_EXEC, given the executing opcode.
//
//   Ports
//     opcode     in   2     opcode of the executing instruction
//     target     in   PC_W  jump target of the executing instruction
//     ovf        in   1     current sticky overflow flag
//     inc_value  in   PC_W  external incrementer sum (pc + 1)
//     inc_carry  in   1     external incrementer carry-out (PC wrapped)
//     next_pc    out  PC_W  PC to commit
//     next_ovf   out  1     overflow flag to commit
//     pc_load    out  1     1 = commit next_pc, 0 = keep the current PC
//
//   Build option PCSEQ_HALT_EN: when defined, OP_HALT keeps the PC and the
//   flag (pc_load = 0); when undefined, OP_HALT behaves exactly like OP_ADV.
// -----------------------------------------------------------------------------
module pc_next_mux
  import pcseq_pkg::*;
#(
  parameter int PC_W = 2
) (
  input  logic [1:0]      opcode,
  input  logic [PC_W-1:0] target,
  input  logic            ovf,
  input  logic [PC_W-1:0] inc_value,
  input  logic            inc_carry,
  output logic [PC_W-1:0] next_pc,
  output logic            next_ovf,
  output logic            pc_load
);

  // Next-PC / next-overflow selection per opcode.
  always_comb begin
    next_pc  = inc_value;
    next_ovf = ovf | inc_carry;
    pc_load  = 1'b1;
    case (opcode)
      OP_ADV: begin
        // Sequential advance; a wrap sets the sticky flag.
        next_pc  = inc_value;
        next_ovf = ovf | inc_carry;
      end
      OP_JNO: begin
        if (ovf == 1'b0) begin
          next_pc  = target;
          next_ovf = 1'b0;
        end else begin
          // Flag is consumed by this instruction, but a fresh wrap on the
          // fall-through advance re-arms it.
          next_pc  = inc_value;
          next_ovf = inc_carry;
        end
      end
      OP_JMP: begin
        next_pc  = target;
        next_ovf = ovf;
      end
      OP_HALT: begin
`ifdef PCSEQ_HALT_EN
        next_pc  = inc_value;
        next_ovf = ovf;
        pc_load  = 1'b0;
`else
        next_pc  = inc_value;
        next_ovf = ovf | inc_carry;
`endif
      end
      default: begin
        next_pc  = inc_value;
        next_ovf = ovf | inc_carry;
        pc_load  = 1'b1;
      end
    endcase
  end

endmodule : pc_next_mux

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter stage wrapped around an external PC incrementer. Holds
//   the PC, fetches one instruction per PC from instruction memory (at most
//   one request outstanding), hands the opcode to the incrementer and commits
//   either the incrementer result or a jump target in a single S_EXEC cycle.
//
//   Parameters
//     PC_W      PC / jump-target width
//     RESET_PC  PC value loaded by reset
//
//   Ports
//     clk             in   1       rising-edge clock
//     reset           in   1       asynchronous, active-high reset
//     run_i           in   1       start/continue; looked at in S_IDLE and S_EXEC
//     pc_o            out  PC_W    registered PC (incrementer prev_value)
//     opcode_o        out  2       registered opcode of last fetch (incrementer instruct)
//     inc_value_i     in   PC_W    incrementer sum, combinational from pc_o
//     inc_carry_i     in   1       incrementer carry-out
//     imem_req_valid  out  1       fetch request valid (registered)
//     imem_req_ready  in   1       memory accepts the request
//     imem_req_addr   out  PC_W    fetch address (always pc_o)
//     imem_rsp_valid  in   1       response valid; only honoured in S_WAIT
//     imem_rsp_data   in   PC_W+2  fetched instruction {opcode, target}
//     ovf_o           out  1       sticky overflow flag
//     retire_o        out  1       high for the single S_EXEC cycle of each instruction
//     halted_o        out  1       FSM sits in S_HALT
//
//   Build option PCSEQ_HALT_EN: when defined, opcode 11 retires without a PC
//   change and parks the FSM in S_HALT until reset. When undefined, opcode 11
//   acts as ADV, S_HALT is unreachable and halted_o is tied low.
// -----------------------------------------------------------------------------
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int PC_W     = 2,
  parameter int RESET_PC = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run_i,
  output logic [PC_W-1:0]              pc_o,
  output logic [1:0]                   opcode_o,
  input  logic [PC_W-1:0]              inc_value_i,
  input  logic                         inc_carry_i,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [PC_W-1:0]              imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [instr_width(PC_W)-1:0] imem_rsp_data,
  output logic                         ovf_o,
  output logic                         retire_o,
  output logic                         halted_o
);

  localparam int              OPC_LSB    = instr_opcode_lsb(PC_W);
  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

  // Registered state.
  pcseq_state_t    state_r;
  logic [PC_W-1:0] pc_r;
  logic            ovf_r;
  logic [1:0]      opcode_r;
  logic [PC_W-1:0] target_r;
  logic            req_valid_r;
  logic            retire_r;

  // Combinational helpers.
  pcseq_state_t    next_state_s;
  logic [1:0]      rsp_opcode_s;
  logic [PC_W-1:0] rsp_target_s;
  logic            fetch_accept_s;
  logic            rsp_take_s;
  logic [PC_W-1:0] next_pc_s;
  logic            next_ovf_s;
  logic            pc_load_s;

  assign rsp_opcode_s   = imem_rsp_data[OPC_LSB +: 2];
  assign rsp_target_s   = imem_rsp_data[INSTR_TARGET_LSB +: PC_W];
  assign fetch_accept_s = req_valid_r & imem_req_ready;
  // A response is only meaningful while a request is outstanding; anything
  // else (including the accept cycle itself) is dropped.
  assign rsp_take_s     = (state_r == S_WAIT) & imem_rsp_valid;

  pc_next_mux #(
    .PC_W (PC_W)
  ) u_next_mux (
    .opcode    (opcode_r),
    .target    (target_r),
    .ovf       (ovf_r),
    .inc_value (inc_value_i),
    .inc_carry (inc_carry_i),
    .next_pc   (next_pc_s),
    .next_ovf  (next_ovf_s),
    .pc_load   (pc_load_s)
  );

  // FSM next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (run_i) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (fetch_accept_s) begin
          next_state_s = S_WAIT;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_WAIT: begin
        if (rsp_take_s) begin
          next_state_s = S_EXEC;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_EXEC: begin
`ifdef PCSEQ_HALT_EN
        if (opcode_r == OP_HALT) begin
          next_state_s = S_HALT;
        end else if (run_i) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
`else
        if (run_i) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
`endif
      end
      S_HALT: begin
`ifdef PCSEQ_HALT_EN
        next_state_s = S_HALT;
`else
        next_state_s = S_IDLE;
`endif
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // FSM state and state-derived outputs, registered from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      req_valid_r <= 1'b0;
      retire_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      req_valid_r <= (next_state_s == S_FETCH);
      retire_r    <= (next_state_s == S_EXEC);
    end
  end

  // Instruction capture on the accepted response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_r <= OP_ADV;
      target_r <= {PC_W{1'b0}};
    end else if (rsp_take_s) begin
      opcode_r <= rsp_opcode_s;
      target_r <= rsp_target_s;
    end else begin
      opcode_r <= opcode_r;
      target_r <= target_r;
    end
  end

  // PC and overflow commit, once per instruction in S_EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r  <= RESET_PC_V;
      ovf_r <= 1'b0;
    end else if (state_r == S_EXEC) begin
      if (pc_load_s) begin
        pc_r <= next_pc_s;
      end else begin
        pc_r <= pc_r;
      end
      ovf_r <= next_ovf_s;
    end else begin
      pc_r  <= pc_r;
      ovf_r <= ovf_r;
    end
  end

`ifdef PCSEQ_HALT_EN
  logic halted_r;

  // Halt indicator, registered like the other state-derived outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (next_state_s == S_HALT);
    end
  end

  assign halted_o = halted_r;
`else
  assign halted_o = 1'b0;
`endif

  assign pc_o           = pc_r;
  assign opcode_o       = opcode_r;
  assign ovf_o          = ovf_r;
  assign retire_o       = retire_r;
  assign imem_req_valid = req_valid_r;
  // The address is the PC itself, which only moves in S_EXEC, so it holds
  // steady for the whole fetch handshake.
  assign imem_req_addr  = pc_r;

endmodule : pc_sequencer
